// File: rtl/xtea_pkg.sv
// Shared types and constants for the XTEA core scheduler.
package xtea_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_RESP    = 3'd4
  } state_e;

  localparam logic MODE_DEC = 1'b0;
  localparam logic MODE_ENC = 1'b1;

  localparam int DEFAULT_TIMEOUT = 128;
  // WAIT cycles from core start until the core's ready pulse
  localparam int CORE_LAT = 98;

  typedef struct packed {
    logic         mode;
    logic [127:0] data;
    logic [127:0] key;
  } req_t;

endpackage

// File: rtl/xtea_sched_rr_arb2.sv
// Two-way round-robin arbiter; the requester other than `last` wins a tie.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last,
  output logic [1:0] grant,
  output logic       any
);

  assign grant[0] = valid[0] & (~valid[1] | last);
  assign grant[1] = valid[1] & (~valid[0] | ~last);
  assign any      = |valid;

endmodule

// File: rtl/xtea_sched.sv
// Time-shares one XTEA core between two requesters with a stall watchdog.
module xtea_sched
  import xtea_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic         req0_mode,
  input  logic [127:0] req0_data,
  input  logic [127:0] req0_key,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic         req1_mode,
  input  logic [127:0] req1_data,
  input  logic [127:0] req1_key,
  output logic         rsp0_valid,
  input  logic         rsp0_ready,
  output logic [127:0] rsp0_data,
  output logic         rsp0_err,
  output logic         rsp1_valid,
  input  logic         rsp1_ready,
  output logic [127:0] rsp1_data,
  output logic         rsp1_err,
  output logic         core_start,
  output logic         core_en,
  output logic [127:0] core_data_i,
  output logic [127:0] core_key,
  input  logic         core_ready,
  input  logic [127:0] core_data_o,
  output logic         busy,
  output logic         grant_id
);

  localparam int             WDW     = $clog2(TIMEOUT) + 1;
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

  state_e          state, state_nxt;
  req_t [1:0]      req;
  req_t            lat;
  logic [1:0]      valid, grant;
  logic            any, last, gid, err, rsp_hs;
  logic [WDW-1:0]  wd;
  logic [127:0]    res;

  assign valid  = {req1_valid, req0_valid};
  assign req[0] = '{mode: req0_mode, data: req0_data, key: req0_key};
  assign req[1] = '{mode: req1_mode, data: req1_data, key: req1_key};

  rr_arb2 u_arb (
    .valid (valid),
    .last  (last),
    .grant (grant),
    .any   (any)
  );

  assign rsp_hs = (state == ST_RESP) && (gid ? rsp1_ready : rsp0_ready);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (any) state_nxt = ST_START;
      ST_START:   state_nxt = ST_WAIT;
      // a ready pulse in the expiry cycle still delivers the real result
      ST_WAIT: begin
        if (core_ready)         state_nxt = ST_CAPTURE;
        else if (wd == WD_LAST) state_nxt = ST_RESP;
      end
      ST_CAPTURE: state_nxt = ST_RESP;
      ST_RESP:    if (rsp_hs) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      last  <= 1'b1;
      gid   <= 1'b0;
      lat   <= '0;
      wd    <= '0;
      res   <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: begin
          if (any) begin
            gid <= grant[1];
            lat <= req[grant[1]];
            wd  <= '0;
          end
        end
        ST_WAIT: begin
          if (wd != '1) wd <= wd + 1'b1;
          if (!core_ready && wd == WD_LAST) begin
            err <= 1'b1;
            res <= '0;
          end
        end
        ST_CAPTURE: begin
          res <= core_data_o;
          err <= 1'b0;
        end
        ST_RESP: if (rsp_hs) last <= gid;
        default: ;
      endcase
    end
  end

  assign req0_ready  = (state == ST_IDLE) & grant[0];
  assign req1_ready  = (state == ST_IDLE) & grant[1];

  assign rsp0_valid  = (state == ST_RESP) & ~gid;
  assign rsp1_valid  = (state == ST_RESP) &  gid;
  assign rsp0_data   = res;
  assign rsp1_data   = res;
  assign rsp0_err    = rsp0_valid & err;
  assign rsp1_err    = rsp1_valid & err;

  assign core_start  = (state == ST_START);
  assign core_en     = lat.mode;
  assign core_data_i = lat.data;
  assign core_key    = lat.key;

  assign busy        = (state != ST_IDLE);
  assign grant_id    = gid;

endmodule
